// File: rtl/ndata_width_downsizer.sv
// ndata_width_downsizer: keep-aware serializer of a wide lane stream into OUT_WIDTH-lane chunks
module ndata_width_downsizer #(
  parameter type data_t = logic [7:0],
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  data_t [IN_WIDTH-1:0]    i_in_data,
  input  logic  [IN_WIDTH-1:0]    i_in_keep,
  input  logic                    i_in_last,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output data_t [OUT_WIDTH-1:0]   o_out_data,
  output logic  [OUT_WIDTH-1:0]   o_out_keep,
  output logic                    o_out_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready
);
  localparam int R = IN_WIDTH / OUT_WIDTH;
  localparam int KW = (R > 1) ? $clog2(R) : 1;
  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  typedef enum logic {EMPTY, EMIT} state_t;
  state_t                  r_state, w_state_nxt;
  data_t [IN_WIDTH-1:0]    r_data;
  logic  [IN_WIDTH-1:0]    r_keep;
  logic                    r_last;
  logic  [R-1:0]           r_pend, w_pend_nxt, w_in_pend, w_rem;
  logic  [KW-1:0]          r_k, w_k_nxt;
  logic                    w_in_hs, w_out_hs;
  function automatic logic [KW-1:0] lsb(input logic [R-1:0] p);
    lsb = '0;
    for (int i = R - 1; i >= 0; i--) if (p[i]) lsb = i[KW-1:0];
  endfunction
  // w_rem: chunks still owed after the current one leaves
  always_comb begin
    for (int j = 0; j < R; j++) begin
      w_in_pend[j] = |i_in_keep[j*OUT_WIDTH +: OUT_WIDTH];
      w_rem[j] = r_pend[j] && (KW'(j) != r_k);
    end
  end
  assign w_in_hs  = i_in_valid && o_in_ready;
  assign w_out_hs = o_out_valid && i_out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_k     <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_k     <= w_k_nxt;
      if (w_in_hs) begin
        r_data <= i_in_data;
        r_keep <= i_in_keep;
        r_last <= i_in_last;
      end
    end
  end
  // an all-empty beat survives only when it must carry last
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_k_nxt     = r_k;
    if (w_in_hs) begin
      w_state_nxt = (|w_in_pend || i_in_last) ? EMIT : EMPTY;
      w_pend_nxt  = w_in_pend;
      w_k_nxt     = lsb(w_in_pend);
    end else if (w_out_hs) begin
      w_state_nxt = |w_rem ? EMIT : EMPTY;
      w_pend_nxt  = w_rem;
      w_k_nxt     = lsb(w_rem);
    end
  end
  always_comb begin
    o_out_valid = r_state == EMIT;
    o_out_data  = r_data[r_k*OUT_WIDTH +: OUT_WIDTH];
    o_out_keep  = r_keep[r_k*OUT_WIDTH +: OUT_WIDTH];
    o_out_last  = o_out_valid && r_last && !(|w_rem);
    o_in_ready  = rst_n && (r_state == EMPTY || (o_out_valid && i_out_ready && !(|w_rem)));
  end
endmodule

// File: tb/tb_ndata_width_downsizer.sv
// tb_ndata_width_downsizer: directed checks of the downsizer at 16->8 and 32->8 lanes
module tb_ndata_width_downsizer;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0][7:0] i16_data;
  logic [15:0]      i16_keep;
  logic             i16_last, i16_valid, o16_in_ready;
  logic [7:0][7:0]  o16_data;
  logic [7:0]       o16_keep;
  logic             o16_last, o16_valid, i16_out_ready;
  logic [31:0][7:0] i32_data;
  logic [31:0]      i32_keep;
  logic             i32_last, i32_valid, o32_in_ready;
  logic [7:0][7:0]  o32_data;
  logic [7:0]       o32_keep;
  logic             o32_last, o32_valid, i32_out_ready;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ndata_width_downsizer #(.data_t(logic [7:0]), .IN_WIDTH(16), .OUT_WIDTH(8)) u16 (
    .clk(clk), .rst_n(rst_n),
    .i_in_data(i16_data), .i_in_keep(i16_keep), .i_in_last(i16_last),
    .i_in_valid(i16_valid), .o_in_ready(o16_in_ready),
    .o_out_data(o16_data), .o_out_keep(o16_keep), .o_out_last(o16_last),
    .o_out_valid(o16_valid), .i_out_ready(i16_out_ready));

  ndata_width_downsizer #(.data_t(logic [7:0]), .IN_WIDTH(32), .OUT_WIDTH(8)) u32 (
    .clk(clk), .rst_n(rst_n),
    .i_in_data(i32_data), .i_in_keep(i32_keep), .i_in_last(i32_last),
    .i_in_valid(i32_valid), .o_in_ready(o32_in_ready),
    .o_out_data(o32_data), .o_out_keep(o32_keep), .o_out_last(o32_last),
    .o_out_valid(o32_valid), .i_out_ready(i32_out_ready));

  function automatic logic [7:0][7:0] lanes(input int b);
    logic [7:0][7:0] r;
    for (int j = 0; j < 8; j++) r[j] = 8'(b + j);
    return r;
  endfunction

  function automatic logic [15:0][7:0] fill16(input int b);
    logic [15:0][7:0] r;
    for (int j = 0; j < 16; j++) r[j] = 8'(b + j);
    return r;
  endfunction

  function automatic logic [31:0][7:0] fill32(input int b);
    logic [31:0][7:0] r;
    for (int j = 0; j < 32; j++) r[j] = 8'(b + j);
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step;
    vectors++;
    if ({o16_valid, o16_last, o16_in_ready, o32_valid, o32_last, o32_in_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b expected 000000",
               {o16_valid, o16_last, o16_in_ready, o32_valid, o32_last, o32_in_ready});
    end
    rst_n = 1'b1;
    step;
    vectors++;
    if ({o16_valid, o16_in_ready, o32_valid, o32_in_ready} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_release got %b expected 0101",
               {o16_valid, o16_in_ready, o32_valid, o32_in_ready});
    end
  endtask

  task automatic test_full_beat;
    i16_data = fill16(0); i16_keep = 16'hFFFF; i16_last = 1'b1; i16_valid = 1'b1;
    #1;
    vectors++;
    if (o16_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_accept in_ready got %b expected 1", o16_in_ready);
    end
    step;
    i16_valid = 1'b0;
    #1;
    vectors++;
    if ({o16_valid, o16_data, o16_keep, o16_last, o16_in_ready} !== {1'b1, lanes(0), 8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL full_chunk0 got %h expected %h",
               {o16_valid, o16_data, o16_keep, o16_last, o16_in_ready}, {1'b1, lanes(0), 8'hFF, 1'b0, 1'b0});
    end
    step;
    vectors++;
    if ({o16_valid, o16_data, o16_keep, o16_last, o16_in_ready} !== {1'b1, lanes(8), 8'hFF, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL full_chunk1 got %h expected %h",
               {o16_valid, o16_data, o16_keep, o16_last, o16_in_ready}, {1'b1, lanes(8), 8'hFF, 1'b1, 1'b1});
    end
    step;
    vectors++;
    if (o16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle valid got %b expected 0", o16_valid);
    end
  endtask

  task automatic test_half_beat;
    i16_data = fill16(8'h20); i16_keep = 16'h00FF; i16_last = 1'b1; i16_valid = 1'b1;
    step;
    i16_data = fill16(8'h40); i16_keep = 16'hFF00;
    #1;
    vectors++;
    if ({o16_valid, o16_data, o16_keep, o16_last, o16_in_ready} !== {1'b1, lanes(8'h20), 8'hFF, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL half_lo got %h expected %h",
               {o16_valid, o16_data, o16_keep, o16_last, o16_in_ready}, {1'b1, lanes(8'h20), 8'hFF, 1'b1, 1'b1});
    end
    step;
    i16_valid = 1'b0;
    #1;
    vectors++;
    if ({o16_valid, o16_data, o16_keep, o16_last} !== {1'b1, lanes(8'h48), 8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL half_hi got %h expected %h",
               {o16_valid, o16_data, o16_keep, o16_last}, {1'b1, lanes(8'h48), 8'hFF, 1'b1});
    end
    step;
    vectors++;
    if (o16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL half_idle valid got %b expected 0", o16_valid);
    end
  endtask

  task automatic test_empty_beats;
    i16_data = fill16(8'h70); i16_keep = 16'h0; i16_last = 1'b0; i16_valid = 1'b1;
    step;
    i16_last = 1'b1;
    #1;
    vectors++;
    if ({o16_valid, o16_in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL empty_drop got %b expected 01", {o16_valid, o16_in_ready});
    end
    step;
    i16_valid = 1'b0;
    #1;
    vectors++;
    if ({o16_valid, o16_keep, o16_last} !== {1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL empty_last got %h expected %h", {o16_valid, o16_keep, o16_last}, {1'b1, 8'h00, 1'b1});
    end
    step;
    vectors++;
    if (o16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_idle valid got %b expected 0", o16_valid);
    end
  endtask

  task automatic test_sparse32;
    i32_data = fill32(8'h80); i32_keep = 32'hFF00FF00; i32_last = 1'b1; i32_valid = 1'b1;
    step;
    i32_valid = 1'b0;
    #1;
    vectors++;
    if ({o32_valid, o32_data, o32_keep, o32_last} !== {1'b1, lanes(8'h88), 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL sparse_chunk1 got %h expected %h",
               {o32_valid, o32_data, o32_keep, o32_last}, {1'b1, lanes(8'h88), 8'hFF, 1'b0});
    end
    step;
    vectors++;
    if ({o32_valid, o32_data, o32_keep, o32_last} !== {1'b1, lanes(8'h98), 8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL sparse_chunk3 got %h expected %h",
               {o32_valid, o32_data, o32_keep, o32_last}, {1'b1, lanes(8'h98), 8'hFF, 1'b1});
    end
    step;
    vectors++;
    if (o32_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sparse_idle valid got %b expected 0", o32_valid);
    end
  endtask

  task automatic test_back_to_back;
    int sent;
    sent = 0;
    i16_data = fill16(0); i16_keep = 16'hFFFF; i16_last = 1'b1; i16_valid = 1'b1;
    #1;
    if (o16_in_ready) sent = 1;
    step;
    for (int n = 0; n < 4; n++) begin
      i16_valid = sent < 2;
      i16_data = fill16(sent * 16);
      #1;
      vectors++;
      if ({o16_valid, o16_data, o16_keep, o16_last} !== {1'b1, lanes(n * 8), 8'hFF, (n % 2) == 1}) begin
        miscompares++;
        $display("FAIL b2b_chunk%0d got %h expected %h", n,
                 {o16_valid, o16_data, o16_keep, o16_last}, {1'b1, lanes(n * 8), 8'hFF, (n % 2) == 1});
      end
      if (i16_valid && o16_in_ready) sent++;
      step;
    end
    i16_valid = 1'b0;
    #1;
    vectors++;
    if ({o16_valid, 32'(sent)} !== {1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL b2b_end valid %b beats %0d expected valid 0 beats 2", o16_valid, sent);
    end
  endtask

  task automatic test_stall;
    int sent, n;
    logic stalled;
    logic [72:0] saved;
    sent = 0; n = 0; stalled = 1'b0; saved = '0;
    i16_keep = 16'hFFFF; i16_last = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      i16_out_ready = (c % 2) == 0;
      i16_valid = sent < 3;
      i16_data = fill16(sent * 16);
      #1;
      if (o16_valid) begin
        if (stalled) begin
          vectors++;
          if ({o16_data, o16_keep, o16_last} !== saved) begin
            miscompares++;
            $display("FAIL stall_stable got %h expected %h", {o16_data, o16_keep, o16_last}, saved);
          end
        end
        if (i16_out_ready) begin
          vectors++;
          if ({o16_data, o16_keep, o16_last} !== {lanes(n * 8), 8'hFF, (n % 2) == 1}) begin
            miscompares++;
            $display("FAIL stall_chunk%0d got %h expected %h", n,
                     {o16_data, o16_keep, o16_last}, {lanes(n * 8), 8'hFF, (n % 2) == 1});
          end
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          saved = {o16_data, o16_keep, o16_last};
          vectors++;
          if (o16_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready got %b expected 0", o16_in_ready);
          end
        end
      end
      if (i16_valid && o16_in_ready) sent++;
      step;
    end
    i16_valid = 1'b0;
    i16_out_ready = 1'b1;
    #1;
    vectors++;
    if ({32'(n), o16_valid} !== {32'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_count got %0d chunks valid %b expected 6 chunks valid 0", n, o16_valid);
    end
  endtask

  task automatic test_reset_mid;
    i16_out_ready = 1'b0;
    i16_data = fill16(8'hA0); i16_keep = 16'hFFFF; i16_last = 1'b1; i16_valid = 1'b1;
    step;
    i16_valid = 1'b0;
    rst_n = 1'b0;
    step;
    vectors++;
    if ({o16_valid, o16_last, o16_in_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got %b expected 000", {o16_valid, o16_last, o16_in_ready});
    end
    rst_n = 1'b1;
    i16_out_ready = 1'b1;
    i16_data = fill16(8'h60); i16_keep = 16'h00FF; i16_valid = 1'b1;
    step;
    i16_valid = 1'b0;
    #1;
    vectors++;
    if ({o16_valid, o16_data, o16_keep, o16_last} !== {1'b1, lanes(8'h60), 8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_mid_fresh got %h expected %h",
               {o16_valid, o16_data, o16_keep, o16_last}, {1'b1, lanes(8'h60), 8'hFF, 1'b1});
    end
    step;
    vectors++;
    if (o16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_leftover valid got %b expected 0", o16_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i16_data = '0; i16_keep = '0; i16_last = 1'b0; i16_valid = 1'b0; i16_out_ready = 1'b1;
    i32_data = '0; i32_keep = '0; i32_last = 1'b0; i32_valid = 1'b0; i32_out_ready = 1'b1;
    test_reset;
    test_full_beat;
    test_half_beat;
    test_empty_beats;
    test_sparse32;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
